// File: rtl/mux4_rr_arbiter_if.sv
// ============================================================================
// Module  : mux4_rr_arbiter_if
// Brief   : Requester/consumer bundle for the four-way round-robin mux arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux4_rr_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]    req;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic [DW-1:0] data_c;
    logic [DW-1:0] data_d;
    logic          out_ready;
    logic [3:0]    gnt;
    logic [3:0]    ack;
    logic [1:0]    sel;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [3:0]    beat_cnt;

    modport master (
        output req, data_a, data_b, data_c, data_d, out_ready,
        input  gnt, ack, sel, out_data, out_valid, beat_cnt
    );

    modport slave (
        input  req, data_a, data_b, data_c, data_d, out_ready,
        output gnt, ack, sel, out_data, out_valid, beat_cnt
    );
endinterface

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// Module  : mux4_rr_arbiter
// Brief   : Round-robin arbiter driving a shared 4:1 data mux with burst capping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    mux4_rr_arbiter_if.slave   bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_GRANT  = 1'b1;
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [1:0]    sel;
    logic [1:0]    sel_nxt;
    logic [3:0]    gnt;
    logic [3:0]    gnt_nxt;
    logic [3:0]    beat_cnt;
    logic [3:0]    beat_cnt_nxt;
    logic [1:0]    last;
    logic [1:0]    last_nxt;

    logic [1:0]    winner;
    logic [1:0]    cand;
    logic          found;
    logic          out_valid;
    logic          accept;
    logic [DW-1:0] data_mux;

    // State register: reset leaves last=3 so requester 0 is searched first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel      <= 2'd0;
            gnt      <= 4'b0000;
            beat_cnt <= 4'd0;
            last     <= 2'd3;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            gnt      <= gnt_nxt;
            beat_cnt <= beat_cnt_nxt;
            last     <= last_nxt;
        end
    end

    // Rotating priority search starting just after the previous owner
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        cand   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        gnt_nxt      = gnt;
        beat_cnt_nxt = beat_cnt;
        last_nxt     = last;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt    = ST_GRANT;
                    sel_nxt      = winner;
                    gnt_nxt      = 4'b0001 << winner;
                    beat_cnt_nxt = 4'd0;
                end
            end
            ST_GRANT: begin
                // sel is deliberately kept so the mux keeps pointing at the last owner
                if (!bus.req[sel] || (accept && (beat_cnt == LAST_BEAT))) begin
                    state_nxt    = ST_IDLE;
                    gnt_nxt      = 4'b0000;
                    beat_cnt_nxt = 4'd0;
                    last_nxt     = sel;
                end else if (accept) begin
                    beat_cnt_nxt = beat_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state == ST_GRANT) && bus.req[sel];
        accept    = out_valid && bus.out_ready;
        case (sel)
            2'd0:    data_mux = bus.data_a;
            2'd1:    data_mux = bus.data_b;
            2'd2:    data_mux = bus.data_c;
            default: data_mux = bus.data_d;
        endcase
    end

    for (genvar i = 0; i < 4; i++) begin : g_ack
        assign bus.ack[i] = accept && (sel == 2'(i));
    end

    assign bus.gnt       = gnt;
    assign bus.sel       = sel;
    assign bus.beat_cnt  = beat_cnt;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_mux;

endmodule

`default_nettype wire
